// File: rtl/perf_pkg.sv
// Shared constants and helpers for the performance-monitor bank.
package perf_pkg;

    // Overflow behaviour selectors for a counter cell.
    localparam int SAT_WRAP = 0;
    localparam int SAT_HOLD = 1;

    // Default counter width for every counter in the bank.
    localparam int CNT_W_DEFAULT = 32;

    // Width of a select field addressing n event channels plus the cycle counter.
    function automatic int sel_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// One unsigned counter with a sticky overflow flag and a synchronous clear.
module perf_counter_cell
    import perf_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEFAULT,
    parameter int SAT_MODE = SAT_WRAP
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // Next count: clear wins over increment; an increment from all-ones wraps or holds and flags overflow.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc_i) begin
            if (&cnt_q) begin
                ovf_d = 1'b1;
                cnt_d = (SAT_MODE == SAT_HOLD) ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter and flag registers, discarded immediately on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_event_counters.sv
// Performance-monitor bank: cycle counter plus NUM_CH event counters,
// cycle-limit freeze, snapshot shadow bank and a registered read port.
module perf_event_counters
    import perf_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = CNT_W_DEFAULT,
    parameter int SAT_MODE = SAT_WRAP
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic                      clear_i,
    input  logic [NUM_CH-1:0]         event_i,
    input  logic [CNT_W-1:0]          limit_i,
    input  logic                      snapshot_i,
    input  logic [sel_w(NUM_CH)-1:0]  rd_sel_i,
    output logic [CNT_W-1:0]          rd_data_o,
    output logic                      snap_valid_o,
    output logic [NUM_CH:0]           ovf_o,
    output logic                      done_o
);

    // Index 0 is the cycle counter, index k is event channel k-1.
    localparam int NCNT = NUM_CH + 1;

    logic             run;
    logic             limit_hit;
    logic [NCNT-1:0]  inc;
    logic [CNT_W-1:0] live [NCNT];

    logic             done_q, done_d;
    logic             snap_valid_q, snap_valid_d;
    logic [CNT_W-1:0] shadow_q [NCNT];
    logic [CNT_W-1:0] shadow_d [NCNT];
    logic [CNT_W-1:0] rd_data_q, rd_data_d;

    assign run       = enable_i & ~done_q;
    assign inc       = {event_i & {NUM_CH{run}}, run};
    // The edge that takes the cycle counter to limit_i is the freezing edge; its events still count.
    assign limit_hit = run && (limit_i != '0) && (live[0] == limit_i - 1'b1);

    for (genvar g = 0; g < NCNT; g++) begin : g_cell
        perf_counter_cell #(
            .CNT_W    (CNT_W),
            .SAT_MODE (SAT_MODE)
        ) u_cell (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (clear_i),
            .inc_i (inc[g]),
            .cnt_o (live[g]),
            .ovf_o (ovf_o[g])
        );
    end

    // Control and shadow/read next state; shadows capture pre-edge live values and ignore clear.
    always_comb begin
        done_d       = done_q;
        snap_valid_d = snapshot_i;
        shadow_d     = shadow_q;
        rd_data_d    = '0;
        if (clear_i) begin
            done_d = 1'b0;
        end else if (limit_hit) begin
            done_d = 1'b1;
        end
        if (snapshot_i) begin
            shadow_d = live;
        end
        if (int'(rd_sel_i) <= NUM_CH) begin
            rd_data_d = shadow_q[rd_sel_i];
        end
    end

    // Bank-level registers, all discarded immediately on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_q       <= 1'b0;
            snap_valid_q <= 1'b0;
            shadow_q     <= '{default: '0};
            rd_data_q    <= '0;
        end else begin
            done_q       <= done_d;
            snap_valid_q <= snap_valid_d;
            shadow_q     <= shadow_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign done_o       = done_q;
    assign snap_valid_o = snap_valid_q;
    assign rd_data_o    = rd_data_q;

endmodule

// File: tb/tb_perf_event_counters.sv
// Directed bench: one wrapping and one saturating 8-bit, 4-channel bank driven in parallel.
module tb_perf_event_counters;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       enable_i;
    logic       clear_i;
    logic [3:0] event_i;
    logic [7:0] limit_i;
    logic       snapshot_i;
    logic [2:0] rd_sel_i;

    logic [7:0] rdw, rds;
    logic       svw, svs;
    logic [4:0] ovfw, ovfs;
    logic       donew, dones;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    perf_event_counters #(.NUM_CH(4), .CNT_W(8), .SAT_MODE(0)) dut_wrap (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i),
        .event_i(event_i), .limit_i(limit_i), .snapshot_i(snapshot_i), .rd_sel_i(rd_sel_i),
        .rd_data_o(rdw), .snap_valid_o(svw), .ovf_o(ovfw), .done_o(donew)
    );

    perf_event_counters #(.NUM_CH(4), .CNT_W(8), .SAT_MODE(1)) dut_sat (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i),
        .event_i(event_i), .limit_i(limit_i), .snapshot_i(snapshot_i), .rd_sel_i(rd_sel_i),
        .rd_data_o(rds), .snap_valid_o(svs), .ovf_o(ovfs), .done_o(dones)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    task automatic do_snap();
        snapshot_i = 1'b1;
        tick();
        snapshot_i = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] sel);
        rd_sel_i = sel;
        tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        vecs++; if (rdw !== 8'd0 || rds !== 8'd0) begin errs++; $display("FAIL reset_rd got %0d/%0d want 0", rdw, rds); end
        vecs++; if (svw !== 1'b0 || svs !== 1'b0) begin errs++; $display("FAIL reset_sv got %b/%b want 0", svw, svs); end
        vecs++; if (ovfw !== 5'd0 || ovfs !== 5'd0) begin errs++; $display("FAIL reset_ovf got %b/%b want 0", ovfw, ovfs); end
        vecs++; if (donew !== 1'b0 || dones !== 1'b0) begin errs++; $display("FAIL reset_done got %b/%b want 0", donew, dones); end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        do_clear();
        enable_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            event_i = {3'b000, (i % 2 == 0)};
            tick();
        end
        enable_i = 1'b0;
        event_i  = 4'b1111;
        for (int i = 0; i < 3; i++) tick();
        event_i = 4'b0000;
        do_snap();
        vecs++; if (svw !== 1'b1 || svs !== 1'b1) begin errs++; $display("FAIL t1_snap_pulse got %b/%b want 1", svw, svs); end
        do_read(3'd0);
        vecs++; if (svw !== 1'b0 || svs !== 1'b0) begin errs++; $display("FAIL t1_snap_once got %b/%b want 0", svw, svs); end
        vecs++; if (rdw !== 8'd10 || rds !== 8'd10) begin errs++; $display("FAIL t1_cycles got %0d/%0d want 10", rdw, rds); end
        do_read(3'd1);
        vecs++; if (rdw !== 8'd5 || rds !== 8'd5) begin errs++; $display("FAIL t1_ch0 got %0d/%0d want 5", rdw, rds); end
        vecs++; if (ovfw !== 5'd0 || ovfs !== 5'd0) begin errs++; $display("FAIL t1_ovf got %b/%b want 0", ovfw, ovfs); end
    endtask

    task automatic test_limit();
        do_clear();
        limit_i  = 8'd7;
        enable_i = 1'b1;
        event_i  = 4'b0010;
        for (int n = 1; n <= 7; n++) begin
            tick();
            vecs++;
            if (donew !== (n == 7) || dones !== (n == 7)) begin
                errs++; $display("FAIL t2_done_edge%0d got %b/%b want %b", n, donew, dones, (n == 7));
            end
        end
        limit_i = 8'd100;
        for (int i = 0; i < 20; i++) tick();
        vecs++; if (donew !== 1'b1 || dones !== 1'b1) begin errs++; $display("FAIL t2_done_held got %b/%b want 1", donew, dones); end
        do_snap();
        enable_i = 1'b0;
        event_i  = 4'b0000;
        do_read(3'd0);
        vecs++; if (rdw !== 8'd7 || rds !== 8'd7) begin errs++; $display("FAIL t2_cycles got %0d/%0d want 7", rdw, rds); end
        do_read(3'd2);
        vecs++; if (rdw !== 8'd7 || rds !== 8'd7) begin errs++; $display("FAIL t2_ch1 got %0d/%0d want 7", rdw, rds); end
        limit_i = 8'd0;
        do_clear();
        vecs++; if (donew !== 1'b0 || dones !== 1'b0) begin errs++; $display("FAIL t2_clear_done got %b/%b want 0", donew, dones); end
    endtask

    task automatic test_overflow();
        do_clear();
        enable_i = 1'b1;
        event_i  = 4'b0001;
        for (int i = 0; i < 257; i++) tick();
        enable_i = 1'b0;
        event_i  = 4'b0000;
        do_snap();
        do_read(3'd1);
        vecs++; if (rdw !== 8'd1) begin errs++; $display("FAIL t3_wrap_ch0 got %0d want 1", rdw); end
        vecs++; if (rds !== 8'd255) begin errs++; $display("FAIL t3_sat_ch0 got %0d want 255", rds); end
        do_read(3'd0);
        vecs++; if (rdw !== 8'd1 || rds !== 8'd255) begin errs++; $display("FAIL t3_cycles got %0d/%0d want 1/255", rdw, rds); end
        vecs++; if (ovfw !== 5'b00011 || ovfs !== 5'b00011) begin errs++; $display("FAIL t3_ovf got %b/%b want 00011", ovfw, ovfs); end
        for (int i = 0; i < 3; i++) tick();
        vecs++; if (ovfw[1] !== 1'b1 || ovfs[1] !== 1'b1) begin errs++; $display("FAIL t3_ovf_sticky got %b/%b want 1", ovfw[1], ovfs[1]); end
        do_clear();
        vecs++; if (ovfw !== 5'd0 || ovfs !== 5'd0) begin errs++; $display("FAIL t3_ovf_clear got %b/%b want 0", ovfw, ovfs); end
    endtask

    task automatic test_same_edge();
        do_clear();
        enable_i = 1'b1;
        event_i  = 4'b0001;
        for (int i = 0; i < 42; i++) tick();
        clear_i    = 1'b1;
        snapshot_i = 1'b1;
        tick();
        clear_i    = 1'b0;
        snapshot_i = 1'b0;
        enable_i   = 1'b0;
        event_i    = 4'b0000;
        vecs++; if (svw !== 1'b1 || svs !== 1'b1) begin errs++; $display("FAIL t4_snap_pulse got %b/%b want 1", svw, svs); end
        do_read(3'd1);
        vecs++; if (svw !== 1'b0 || svs !== 1'b0) begin errs++; $display("FAIL t4_snap_once got %b/%b want 0", svw, svs); end
        vecs++; if (rdw !== 8'd42 || rds !== 8'd42) begin errs++; $display("FAIL t4_shadow_ch0 got %0d/%0d want 42", rdw, rds); end
        do_snap();
        do_read(3'd1);
        vecs++; if (rdw !== 8'd0 || rds !== 8'd0) begin errs++; $display("FAIL t4_live_ch0 got %0d/%0d want 0", rdw, rds); end
    endtask

    task automatic test_async_reset();
        do_clear();
        enable_i = 1'b1;
        event_i  = 4'b0001;
        for (int i = 0; i < 100; i++) tick();
        enable_i = 1'b0;
        event_i  = 4'b0000;
        do_snap();
        do_read(3'd1);
        vecs++; if (rdw !== 8'd100 || rds !== 8'd100) begin errs++; $display("FAIL t5_pre got %0d/%0d want 100", rdw, rds); end
        #2;
        rst_i = 1'b1;
        #1;
        vecs++; if (rdw !== 8'd0 || rds !== 8'd0) begin errs++; $display("FAIL t5_rd_async got %0d/%0d want 0", rdw, rds); end
        vecs++; if (ovfw !== 5'd0 || donew !== 1'b0 || svw !== 1'b0) begin errs++; $display("FAIL t5_flags_async got %b/%b/%b want 0", ovfw, donew, svw); end
        rst_i = 1'b0;
        do_read(3'd1);
        vecs++; if (rdw !== 8'd0 || rds !== 8'd0) begin errs++; $display("FAIL t5_shadow_reset got %0d/%0d want 0", rdw, rds); end
        enable_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            event_i = {3'b000, (i % 2 == 0)};
            tick();
        end
        enable_i = 1'b0;
        event_i  = 4'b0000;
        do_snap();
        do_read(3'd0);
        vecs++; if (rdw !== 8'd4 || rds !== 8'd4) begin errs++; $display("FAIL t5_resume_cyc got %0d/%0d want 4", rdw, rds); end
    endtask

    task automatic test_read_port();
        do_read(3'd5);
        vecs++; if (rdw !== 8'd0 || rds !== 8'd0) begin errs++; $display("FAIL t6_sel5 got %0d/%0d want 0", rdw, rds); end
        do_read(3'd0);
        vecs++; if (rdw !== 8'd4 || rds !== 8'd4) begin errs++; $display("FAIL t6_sel0 got %0d/%0d want 4", rdw, rds); end
        rd_sel_i = 3'd1;
        #1;
        vecs++; if (rdw !== 8'd4 || rds !== 8'd4) begin errs++; $display("FAIL t6_latency_hold got %0d/%0d want 4", rdw, rds); end
        tick();
        vecs++; if (rdw !== 8'd2 || rds !== 8'd2) begin errs++; $display("FAIL t6_latency_new got %0d/%0d want 2", rdw, rds); end
        do_read(3'd7);
        vecs++; if (rdw !== 8'd0 || rds !== 8'd0) begin errs++; $display("FAIL t6_sel7 got %0d/%0d want 0", rdw, rds); end
        enable_i = 1'b1;
        event_i  = 4'b0001;
        for (int i = 0; i < 3; i++) tick();
        enable_i   = 1'b0;
        event_i    = 4'b0000;
        snapshot_i = 1'b1;
        do_read(3'd1);
        snapshot_i = 1'b0;
        vecs++; if (rdw !== 8'd2 || rds !== 8'd2) begin errs++; $display("FAIL t6_read_old got %0d/%0d want 2", rdw, rds); end
        do_read(3'd1);
        vecs++; if (rdw !== 8'd5 || rds !== 8'd5) begin errs++; $display("FAIL t6_read_new got %0d/%0d want 5", rdw, rds); end
    endtask

    task automatic test_back_to_back();
        enable_i   = 1'b1;
        event_i    = 4'b0001;
        snapshot_i = 1'b1;
        tick();
        vecs++; if (svw !== 1'b1 || svs !== 1'b1) begin errs++; $display("FAIL b2b_pulse1 got %b/%b want 1", svw, svs); end
        tick();
        vecs++; if (svw !== 1'b1 || svs !== 1'b1) begin errs++; $display("FAIL b2b_pulse2 got %b/%b want 1", svw, svs); end
        snapshot_i = 1'b0;
        enable_i   = 1'b0;
        event_i    = 4'b0000;
        do_read(3'd1);
        vecs++; if (svw !== 1'b0 || svs !== 1'b0) begin errs++; $display("FAIL b2b_pulse_end got %b/%b want 0", svw, svs); end
        vecs++; if (rdw !== 8'd6 || rds !== 8'd6) begin errs++; $display("FAIL b2b_ch0 got %0d/%0d want 6", rdw, rds); end
        do_read(3'd0);
        vecs++; if (rdw !== 8'd8 || rds !== 8'd8) begin errs++; $display("FAIL b2b_cycles got %0d/%0d want 8", rdw, rds); end
    endtask

    initial begin
        rst_i      = 1'b1;
        enable_i   = 1'b0;
        clear_i    = 1'b0;
        event_i    = 4'b0000;
        limit_i    = 8'd0;
        snapshot_i = 1'b0;
        rd_sel_i   = 3'd0;
        tick();
        test_reset();
        test_basic();
        test_limit();
        test_overflow();
        test_same_edge();
        test_async_reset();
        test_read_port();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
